lsu_rs: RTL and testbench

- In-order reservation station for memory operations, sitting directly upstream of the LSU functional unit.
- Accepts renamed memory ops from dispatch and tracks rs1/rs2 operand readiness by snooping the CDB tag broadcasts.
- Issues the oldest entry to the LSU functional unit once that entry's operands are ready and the unit signals ready.
- Strict program-order issue: memory ordering is preserved without a disambiguation unit.

---
 rtl/lsu_rs_pkg.sv | 26 ++
 rtl/lsu_rs_if.sv | 29 ++
 rtl/lsu_rs_wakeup.sv | 15 +
 rtl/lsu_rs.sv | 75 +++++++
 tb/tb_lsu_rs.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_rs_pkg.sv
// Shared types for the LSU reservation station: renamed memory-op packet and sizing constants.
package lsu_rs_pkg;
  localparam int XLEN         = 32;
  localparam int PREG_W       = 6;
  localparam int ROB_TAG_W    = 5;
  localparam int LSU_RS_DEPTH = 8;

  typedef struct packed {
    logic [PREG_W-1:0]    rs1_tag;
    logic [PREG_W-1:0]    rs2_tag;
    logic [PREG_W-1:0]    rd_tag;
    logic                 rd_used;
    logic [XLEN-1:0]      imm;
    logic                 imm_used;
    logic                 is_load;
    logic                 is_store;
    logic [1:0]           ls_size;
    logic                 unsigned_load;
    logic [ROB_TAG_W-1:0] rob_tag;
  } issue_pkt_t;

  // Stores always read rs2 as data even though they carry an immediate offset.
  function automatic logic rs2_needed(input issue_pkt_t p);
    return !p.imm_used || p.is_store;
  endfunction
endpackage

// File: rtl/lsu_rs_if.sv
// Dispatch / CDB snoop / issue bundle between dispatch, the LSU RS and the LSU functional unit.
interface lsu_rs_if import lsu_rs_pkg::*; #(
  parameter int DEPTH   = LSU_RS_DEPTH,
  parameter int NUM_CDB = 2
);
  logic                             flush_i;
  logic                             dispatch_valid_i;
  logic                             dispatch_ready_o;
  issue_pkt_t                       dispatch_pkt_i;
  logic                             dispatch_rs1_rdy_i;
  logic                             dispatch_rs2_rdy_i;
  logic [NUM_CDB-1:0]               cdb_valid_i;
  logic [NUM_CDB-1:0][PREG_W-1:0]   cdb_tag_i;
  logic                             issue_valid_o;
  logic                             issue_ready_i;
  issue_pkt_t                       issue_pkt_o;
  logic [$clog2(DEPTH):0]           count_o;

  modport master (
    output flush_i, dispatch_valid_i, dispatch_pkt_i, dispatch_rs1_rdy_i, dispatch_rs2_rdy_i,
           cdb_valid_i, cdb_tag_i, issue_ready_i,
    input  dispatch_ready_o, issue_valid_o, issue_pkt_o, count_o
  );
  modport slave (
    input  flush_i, dispatch_valid_i, dispatch_pkt_i, dispatch_rs1_rdy_i, dispatch_rs2_rdy_i,
           cdb_valid_i, cdb_tag_i, issue_ready_i,
    output dispatch_ready_o, issue_valid_o, issue_pkt_o, count_o
  );
endinterface

// File: rtl/lsu_rs_wakeup.sv
// Combinational tag matcher: one operand tag against every CDB broadcast port.
module lsu_rs_wakeup import lsu_rs_pkg::*; #(
  parameter int NUM_CDB = 2
) (
  input  logic [PREG_W-1:0]               tag,
  input  logic [NUM_CDB-1:0]              cdb_valid,
  input  logic [NUM_CDB-1:0][PREG_W-1:0]  cdb_tag,
  output logic                            match
);
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb_valid[k] && (cdb_tag[k] == tag)) match = 1'b1;
  end
endmodule

// File: rtl/lsu_rs.sv
// In-order reservation station for memory ops: circular buffer, CDB wakeup, oldest-first issue.
module lsu_rs import lsu_rs_pkg::*; #(
  parameter int DEPTH   = LSU_RS_DEPTH,
  parameter int NUM_CDB = 2
) (
  input  logic   clk,
  input  logic   rst,
  lsu_rs_if.slave io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  issue_pkt_t       pkt_q [DEPTH];
  logic [DEPTH-1:0] rs1_rdy_q, rs2_rdy_q;
  logic [DEPTH-1:0] wk1, wk2;
  logic             byp1, byp2;
  logic             disp_fire, iss_fire, head_rdy, not_empty;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    lsu_rs_wakeup #(.NUM_CDB(NUM_CDB)) u_wk1 (
      .tag(pkt_q[i].rs1_tag), .cdb_valid(io.cdb_valid_i), .cdb_tag(io.cdb_tag_i), .match(wk1[i]));
    lsu_rs_wakeup #(.NUM_CDB(NUM_CDB)) u_wk2 (
      .tag(pkt_q[i].rs2_tag), .cdb_valid(io.cdb_valid_i), .cdb_tag(io.cdb_tag_i), .match(wk2[i]));
  end

  // Same-cycle bypass so an op dispatched alongside its producer's broadcast is not missed.
  lsu_rs_wakeup #(.NUM_CDB(NUM_CDB)) u_byp1 (
    .tag(io.dispatch_pkt_i.rs1_tag), .cdb_valid(io.cdb_valid_i), .cdb_tag(io.cdb_tag_i), .match(byp1));
  lsu_rs_wakeup #(.NUM_CDB(NUM_CDB)) u_byp2 (
    .tag(io.dispatch_pkt_i.rs2_tag), .cdb_valid(io.cdb_valid_i), .cdb_tag(io.cdb_tag_i), .match(byp2));

  assign not_empty           = (count_q != '0);
  assign head_rdy            = rs1_rdy_q[head_q] && rs2_rdy_q[head_q];
  assign io.dispatch_ready_o = (count_q < CNT_W'(DEPTH));
  assign io.issue_valid_o    = not_empty && head_rdy;
  assign io.issue_pkt_o      = not_empty ? pkt_q[head_q] : '0;
  assign io.count_o          = count_q;
  assign disp_fire           = io.dispatch_valid_i && io.dispatch_ready_o;
  assign iss_fire            = io.issue_valid_o && io.issue_ready_i;

  // Payload needs no reset: it is masked whenever the station is empty.
  always_ff @(posedge clk) begin
    if (disp_fire && !rst && !io.flush_i) pkt_q[tail_q] <= io.dispatch_pkt_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
    end else if (io.flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rs1_rdy_q <= rs1_rdy_q | wk1;
      rs2_rdy_q <= rs2_rdy_q | wk2;
      if (disp_fire) begin
        rs1_rdy_q[tail_q] <= io.dispatch_rs1_rdy_i || byp1;
        rs2_rdy_q[tail_q] <= io.dispatch_rs2_rdy_i || byp2 || !rs2_needed(io.dispatch_pkt_i);
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (iss_fire) head_q <= head_q + PTR_W'(1);
      case ({disp_fire, iss_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_rs.sv
// Randomized + directed bench for lsu_rs against a queue-based reference model.
module tb_lsu_rs;
  import lsu_rs_pkg::*;
  localparam int DEPTH   = LSU_RS_DEPTH;
  localparam int NUM_CDB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_rs_if #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) io ();
  lsu_rs #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (.clk(clk), .rst(rst), .io(io));

  typedef struct { issue_pkt_t pkt; bit r1; bit r2; } ent_t;
  ent_t q[$];
  bit   known = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [PREG_W-1:0] t);
    for (int k = 0; k < NUM_CDB; k++)
      if (io.cdb_valid_i[k] && io.cdb_tag_i[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic issue_pkt_t mk_pkt(input int rob, input int r1, input int r2,
                                        input bit st, input bit iu);
    issue_pkt_t p = '0;
    p.rs1_tag  = PREG_W'(r1);
    p.rs2_tag  = PREG_W'(r2);
    p.rd_tag   = PREG_W'(rob);
    p.rd_used  = !st;
    p.imm      = 32'h10;
    p.imm_used = iu;
    p.is_load  = !st;
    p.is_store = st;
    p.ls_size  = 2'd2;
    p.rob_tag  = ROB_TAG_W'(rob);
    return p;
  endfunction

  // Check outputs against the model, advance the model by one clock, then step the clock.
  task automatic cycle();
    bit dr = 0, ev = 0;
    issue_pkt_t ep = '0;
    ent_t e;
    if (known) begin
      dr = q.size() < DEPTH;
      ev = (q.size() > 0) && q[0].r1 && q[0].r2;
      if (q.size() > 0) ep = q[0].pkt;
      chk("count",    64'(io.count_o),          64'(q.size()));
      chk("disp_rdy", 64'(io.dispatch_ready_o), 64'(dr));
      chk("iss_vld",  64'(io.issue_valid_o),    64'(ev));
      chk("iss_pkt",  64'(io.issue_pkt_o),      64'(ep));
    end
    if (rst) begin
      q.delete();
      known = 1;
    end else if (io.flush_i) begin
      q.delete();
    end else if (known) begin
      foreach (q[i]) begin
        if (hit(q[i].pkt.rs1_tag)) q[i].r1 = 1;
        if (hit(q[i].pkt.rs2_tag)) q[i].r2 = 1;
      end
      if (ev && io.issue_ready_i) void'(q.pop_front());
      if (io.dispatch_valid_i && dr) begin
        e.pkt = io.dispatch_pkt_i;
        e.r1  = io.dispatch_rs1_rdy_i || hit(e.pkt.rs1_tag);
        e.r2  = io.dispatch_rs2_rdy_i || hit(e.pkt.rs2_tag) ||
                !(e.pkt.is_store || !e.pkt.imm_used);
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic disp(input issue_pkt_t p, input bit r1, input bit r2);
    io.dispatch_valid_i   = 1'b1;
    io.dispatch_pkt_i     = p;
    io.dispatch_rs1_rdy_i = r1;
    io.dispatch_rs2_rdy_i = r2;
  endtask

  task automatic quiet();
    io.dispatch_valid_i = 1'b0;
    io.cdb_valid_i      = '0;
    io.flush_i          = 1'b0;
  endtask

  initial begin
    io.flush_i = 1'b0; io.dispatch_valid_i = 1'b0; io.dispatch_pkt_i = '0;
    io.dispatch_rs1_rdy_i = 1'b0; io.dispatch_rs2_rdy_i = 1'b0;
    io.cdb_valid_i = '0; io.cdb_tag_i = '0; io.issue_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_vld", 64'(io.issue_valid_o), 64'd0);
    chk("rst_rdy", 64'(io.dispatch_ready_o), 64'd1);
    chk("rst_cnt", 64'(io.count_o), 64'd0);
    chk("rst_pkt", 64'(io.issue_pkt_o), 64'd0);

    // Ready load issues the cycle after dispatch
    io.issue_ready_i = 1'b1;
    disp(mk_pkt(3, 1, 2, 0, 1), 1, 0); cycle(); quiet();
    chk("t1_vld", 64'(io.issue_valid_o), 64'd1);
    chk("t1_rob", 64'(io.issue_pkt_o.rob_tag), 64'd3);
    chk("t1_cnt1", 64'(io.count_o), 64'd1);
    cycle();
    chk("t1_cnt0", 64'(io.count_o), 64'd0);

    // CDB wakeup on port 1
    disp(mk_pkt(4, 5, 0, 0, 1), 0, 0); cycle(); quiet();
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait", 64'(io.issue_valid_o), 64'd0);
      cycle();
    end
    io.cdb_valid_i = 2'b10; io.cdb_tag_i[1] = PREG_W'(5); cycle(); quiet();
    chk("t2_wake", 64'(io.issue_valid_o), 64'd1);
    chk("t2_rob", 64'(io.issue_pkt_o.rob_tag), 64'd4);
    cycle();

    // Head-of-line blocking keeps program order
    disp(mk_pkt(5, 7, 0, 0, 1), 0, 0); cycle();
    disp(mk_pkt(6, 1, 0, 0, 1), 1, 0); cycle(); quiet(); cycle();
    chk("t3_hol", 64'(io.issue_valid_o), 64'd0);
    chk("t3_cnt", 64'(io.count_o), 64'd2);
    io.cdb_valid_i = 2'b01; io.cdb_tag_i[0] = PREG_W'(7); cycle(); quiet();
    chk("t3_a", 64'(io.issue_pkt_o.rob_tag), 64'd5);
    chk("t3_a_vld", 64'(io.issue_valid_o), 64'd1);
    cycle();
    chk("t3_b", 64'(io.issue_pkt_o.rob_tag), 64'd6);
    chk("t3_b_vld", 64'(io.issue_valid_o), 64'd1);
    cycle();

    // Store rs2 caught by same-cycle bypass
    disp(mk_pkt(7, 1, 9, 1, 1), 1, 0);
    io.cdb_valid_i = 2'b01; io.cdb_tag_i[0] = PREG_W'(9); cycle(); quiet();
    chk("t4_vld", 64'(io.issue_valid_o), 64'd1);
    chk("t4_rob", 64'(io.issue_pkt_o.rob_tag), 64'd7);
    cycle();

    // Fill, full stall, drain, refill across the wrap
    for (int r = 0; r < 2; r++) begin
      io.issue_ready_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin disp(mk_pkt(r*8+i, 1, 2, 0, 1), 1, 0); cycle(); end
      chk("t5_full", 64'(io.dispatch_ready_o), 64'd0);
      chk("t5_cnt8", 64'(io.count_o), 64'(DEPTH));
      disp(mk_pkt(31, 1, 2, 0, 1), 1, 0); io.issue_ready_i = 1'b1; cycle(); quiet();
      for (int i = 1; i < DEPTH; i++) begin
        chk("t5_order", 64'(io.issue_pkt_o.rob_tag), 64'(r*8+i));
        cycle();
      end
      chk("t5_empty", 64'(io.count_o), 64'd0);
    end

    // Flush and mid-stream reset
    io.issue_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin disp(mk_pkt(i, 3, 0, 0, 1), 0, 0); cycle(); end
    quiet(); io.flush_i = 1'b1; cycle(); io.flush_i = 1'b0;
    chk("t6_fl_cnt", 64'(io.count_o), 64'd0);
    chk("t6_fl_vld", 64'(io.issue_valid_o), 64'd0);
    for (int i = 0; i < 3; i++) begin disp(mk_pkt(i, 1, 0, 0, 1), 1, 0); cycle(); end
    quiet(); rst = 1'b1; cycle(); rst = 1'b0;
    chk("t6_rst_cnt", 64'(io.count_o), 64'd0);
    chk("t6_rst_vld", 64'(io.issue_valid_o), 64'd0);
    chk("t6_rst_rdy", 64'(io.dispatch_ready_o), 64'd1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      issue_pkt_t p;
      rst        = ($urandom_range(299) == 0);
      io.flush_i = ($urandom_range(59) == 0);
      p = mk_pkt(int'($urandom_range(31)), int'($urandom_range(7)), int'($urandom_range(7)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
      p.imm = $urandom;
      p.unsigned_load = 1'($urandom_range(1));
      disp(p, 1'($urandom_range(1)), 1'($urandom_range(1)));
      io.dispatch_valid_i = ($urandom_range(3) != 0);
      for (int k = 0; k < NUM_CDB; k++) begin
        io.cdb_valid_i[k] = ($urandom_range(2) == 0);
        io.cdb_tag_i[k]   = PREG_W'($urandom_range(7));
      end
      io.issue_ready_i = ($urandom_range(3) != 0);
      cycle();
    end
    rst = 1'b0; quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
